// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch controller: holds the architectural PC,
// fetches from instruction memory and hands words to IF/ID over a valid/stall handshake.
module pc_fetch_ctrl #(
    parameter int unsigned           ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]     RESET_PC = ADDR_W'(0)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] npc_in,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc_out,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_imem_req;
    logic              r_if_valid;
    logic [31:0]       r_if_instr;
    logic [ADDR_W-1:0] r_if_pc;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [31:0]       w_if_instr_nxt;
    logic [ADDR_W-1:0] w_if_pc_nxt;
    logic              w_imem_req_nxt;
    logic              w_if_valid_nxt;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_npc;
    logic              w_unused;

    // Word alignment is forced on every PC source.
    assign w_br_tgt = {br_target[ADDR_W-1:2], 2'b00};
    assign w_npc    = {npc_in[ADDR_W-1:2], 2'b00};
    assign w_unused = ^{br_target[1:0], npc_in[1:0]};

    // Next-state and next-datapath decode; redirect always has top priority.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_instr_nxt = r_if_instr;
        w_if_pc_nxt    = r_if_pc;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
                if (br_taken) begin
                    w_pc_nxt = w_br_tgt;
                end
            end
            ST_FETCH: begin
                if (br_taken) begin
                    w_pc_nxt = w_br_tgt;
                end else if (imem_ack) begin
                    w_if_instr_nxt = imem_rdata;
                    w_if_pc_nxt    = r_pc;
                    w_pc_nxt       = w_npc;
                    w_state_nxt    = ST_VALID;
                end
            end
            ST_VALID: begin
                if (br_taken) begin
                    w_pc_nxt    = w_br_tgt;
                    w_state_nxt = ST_FETCH;
                end else if (!stall) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_imem_req_nxt = (w_state_nxt == ST_FETCH);
        w_if_valid_nxt = (w_state_nxt == ST_VALID);
    end

    // Request and valid are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_imem_req <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_instr <= 32'd0;
            r_if_pc    <= ADDR_W'(0);
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_imem_req <= w_imem_req_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc    <= w_if_pc_nxt;
        end
    end

    assign pc_out    = r_pc;
    assign imem_addr = r_pc;
    assign imem_req  = r_imem_req;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: fixed vector table, directed corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] npc_in;
    logic        br_taken;
    logic [11:0] br_target;
    logic        stall;
    logic [11:0] pc_out;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [11:0] if_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign npc_in = pc_out + 12'd4;

    pc_fetch_ctrl #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .npc_in(npc_in), .br_taken(br_taken),
        .br_target(br_target), .stall(stall), .pc_out(pc_out),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc)
    );

    function automatic logic [31:0] memf(input logic [11:0] a);
        if (a == 12'h014) return 32'h8C22_0004;
        return {a, a, 8'h5A};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: "started" after the post-reset idle cycle, "have" while an instruction is held.
    logic        m_started, m_have;
    logic [11:0] m_pc, m_ipc;
    logic [31:0] m_instr;

    task automatic step(input logic rn, input logic br, input logic [11:0] tg,
                        input logic st, input logic ack);
        logic [31:0] rd;
        rst_n = rn; br_taken = br; br_target = tg; stall = st; imem_ack = ack;
        rd = memf(pc_out);
        imem_rdata = rd;
        @(posedge clk);
        if (!rn) begin
            m_started = 1'b0; m_have = 1'b0; m_pc = 12'h000; m_ipc = 12'h000; m_instr = 32'd0;
        end else if (!m_started) begin
            m_started = 1'b1;
            if (br) m_pc = {tg[11:2], 2'b00};
        end else if (m_have) begin
            if (br) begin
                m_have = 1'b0; m_pc = {tg[11:2], 2'b00};
            end else if (!st) begin
                m_have = 1'b0;
            end
        end else begin
            if (br) begin
                m_pc = {tg[11:2], 2'b00};
            end else if (ack) begin
                m_instr = rd; m_ipc = m_pc; m_pc = m_pc + 12'd4; m_have = 1'b1;
            end
        end
        #1;
        chk("model_pc", 32'(pc_out), 32'(m_pc));
        chk("model_req", 32'(imem_req), 32'(m_started && !m_have));
        chk("model_valid", 32'(if_valid), 32'(m_have));
        chk("model_if_pc", 32'(if_pc), 32'(m_ipc));
        chk("model_if_instr", if_instr, m_instr);
        if (imem_req) chk("model_addr", 32'(imem_addr), 32'(pc_out));
    endtask

    typedef struct {
        logic        rn;
        logic        br;
        logic [11:0] tg;
        logic        st;
        logic        ack;
        logic [11:0] e_pc;
        logic        e_req;
        logic        e_valid;
        logic [11:0] e_ipc;
        logic        e_zero_instr;
    } vec_t;

    vec_t vt [15];

    initial begin
        int req_cnt, val_cnt;
        logic [31:0] held_instr;
        rst_n = 1'b0; br_taken = 1'b0; br_target = 12'h000; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'd0;

        //           rn   br   tg       st   ack  pc       req  val  ipc      zero
        vt[0]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1};
        vt[1]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1};
        vt[2]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h004, 1'b0, 1'b1, 12'h000, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h004, 1'b0, 1'b1, 12'h000, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h004, 1'b1, 1'b0, 12'h000, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 12'h203, 1'b0, 1'b1, 12'h200, 1'b1, 1'b0, 12'h000, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h204, 1'b0, 1'b1, 12'h200, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 12'h100, 1'b1, 1'b0, 12'h100, 1'b1, 1'b0, 12'h200, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h100, 1'b1, 1'b0, 12'h200, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h104, 1'b0, 1'b1, 12'h100, 1'b0};
        vt[10] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1};
        vt[11] = '{1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0, 12'hFFC, 1'b1, 1'b0, 12'h000, 1'b1};
        vt[12] = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 12'hFFC, 1'b0};
        vt[13] = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'hFFC, 1'b0};
        vt[14] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1};

        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            rst_n = vt[i].rn; br_taken = vt[i].br; br_target = vt[i].tg;
            stall = vt[i].st; imem_ack = vt[i].ack; imem_rdata = memf(pc_out);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pc", i), 32'(pc_out), 32'(vt[i].e_pc));
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vt[i].e_req));
            chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_if_pc", i), 32'(if_pc), 32'(vt[i].e_ipc));
            chk($sformatf("vec%0d_if_instr", i), if_instr,
                vt[i].e_zero_instr ? 32'd0 : memf(vt[i].e_ipc));
        end

        // Wait states: ack withheld for 3 cycles at 0x010.
        step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        req_cnt = 0; val_cnt = 0;
        step(1'b1, 1'b1, 12'h010, 1'b0, 1'b0);
        if (imem_req && imem_addr == 12'h010) req_cnt++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
            if (imem_req && imem_addr == 12'h010) req_cnt++;
        end
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
        if (imem_req && imem_addr == 12'h010) req_cnt++;
        if (if_valid && if_pc == 12'h010) val_cnt++;
        chk("wait_req_cycles", 32'(req_cnt), 32'd4);
        chk("wait_valid_once", 32'(val_cnt), 32'd1);

        // Stall held 5 cycles on 0x8C220004 fetched from 0x014.
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
        held_instr = if_instr;
        chk("stall_instr_word", held_instr, 32'h8C22_0004);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
            chk("stall_instr_hold", if_instr, 32'h8C22_0004);
            chk("stall_pc_hold", 32'(if_pc), 32'h014);
            chk("stall_no_req", 32'(imem_req), 32'd0);
        end
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        chk("stall_release_req", 32'(imem_req), 32'd1);
        chk("stall_release_addr", 32'(imem_addr), 32'h018);

        // Redirect held high for several cycles: no fetch completes.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 12'h3A1 + 12'(i * 8), 1'b0, 1'b1);
            chk("br_hold_no_valid", 32'(if_valid), 32'd0);
        end

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0),
                 12'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
